// File: rtl/multicycle_microprocessor.sv
// Multi-cycle 4-op core (add/lw/sw/beq) with a fetch handshake, a retire pulse and sticky overflow.
// Every architectural state element clears on a synchronous active-high RST.
module multicycle_microprocessor #(
    parameter int DATA_W     = 8,
    parameter int RA_W       = 2,
    parameter int PC_W       = 8,
    parameter int DMEM_DEPTH = 16,
    parameter int DBG_REG    = 1,
    localparam int INSTR_W   = 2 + 3 * RA_W
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [PC_W-1:0]    PCOutput,
    output logic               retire,
    output logic               overflow,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam int NUM_REGS = 2 ** RA_W;
    localparam int DMEM_AW  = $clog2(DMEM_DEPTH);
    localparam logic [RA_W-1:0] DBG_IDX = DBG_REG[RA_W-1:0];

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MEM   = 2'd2;
    localparam logic [1:0] WB    = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    logic [1:0]         state;
    logic [INSTR_W-1:0] instrReg;
    logic [DATA_W-1:0]  aluOut;
    logic [DATA_W-1:0]  memData;
    logic [DATA_W-1:0]  regFile [NUM_REGS];
    logic [DATA_W-1:0]  dataMem [DMEM_DEPTH];

    // Decode always works from the latched instruction, never from the live input.
    logic [1:0]         opcode;
    logic [RA_W-1:0]    rsIdx;
    logic [RA_W-1:0]    rtIdx;
    logic [RA_W-1:0]    rdImm;
    logic [DATA_W-1:0]  rsVal;
    logic [DATA_W-1:0]  rtVal;
    logic [DATA_W-1:0]  immData;
    logic [PC_W-1:0]    immPc;
    logic [DATA_W-1:0]  aluB;
    logic [DATA_W-1:0]  aluSum;
    logic               aluOvf;
    logic [DMEM_AW-1:0] memAddr;
    logic [PC_W-1:0]    pcNext;
    logic [PC_W-1:0]    branchTarget;

    assign opcode  = instrReg[INSTR_W-1 -: 2];
    assign rsIdx   = instrReg[3*RA_W-1 -: RA_W];
    assign rtIdx   = instrReg[2*RA_W-1 -: RA_W];
    assign rdImm   = instrReg[RA_W-1:0];
    assign rsVal   = regFile[rsIdx];
    assign rtVal   = regFile[rtIdx];
    assign immData = {{(DATA_W-RA_W){rdImm[RA_W-1]}}, rdImm};
    assign immPc   = {{(PC_W-RA_W){rdImm[RA_W-1]}}, rdImm};

    assign aluB    = (opcode == OP_ADD) ? rtVal : immData;
    assign aluSum  = rsVal + aluB;
    // Signed overflow: operands agree in sign but the sum does not.
    assign aluOvf  = (rsVal[DATA_W-1] == aluB[DATA_W-1]) && (aluSum[DATA_W-1] != rsVal[DATA_W-1]);
    assign memAddr = aluOut[DMEM_AW-1:0];

    assign pcNext       = PCOutput + 1'b1;
    assign branchTarget = pcNext + immPc;

    // NOTE: plain continuous assigns for combinational outputs leave no path that could infer a latch.
    assign instr_ready = (state == FETCH) && !RST;
    assign dbg_data    = regFile[DBG_IDX];

    // NOTE: every sequential update uses <= so all state samples pre-edge values in the same cycle.
    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= FETCH;
            PCOutput <= '0;
            retire   <= 1'b0;
            overflow <= 1'b0;
            instrReg <= '0;
            aluOut   <= '0;
            memData  <= '0;
            // NOTE: register file and data memory are reset here on purpose; this forces flops, not RAM macros.
            regFile  <= '{default: '0};
            dataMem  <= '{default: '0};
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        instrReg <= instruction;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    aluOut <= aluSum;
                    if (opcode == OP_BEQ) begin
                        PCOutput <= (rsVal == rtVal) ? branchTarget : pcNext;
                        retire   <= 1'b1;
                        state    <= FETCH;
                    end else begin
                        if (aluOvf) overflow <= 1'b1;
                        state <= (opcode == OP_ADD) ? WB : MEM;
                    end
                end
                MEM: begin
                    if (opcode == OP_LW) begin
                        memData <= dataMem[memAddr];
                        state   <= WB;
                    end else begin
                        dataMem[memAddr] <= rtVal;
                        PCOutput         <= pcNext;
                        retire           <= 1'b1;
                        state            <= FETCH;
                    end
                end
                WB: begin
                    if (opcode == OP_ADD) regFile[rdImm] <= aluOut;
                    else                  regFile[rtIdx] <= memData;
                    PCOutput <= pcNext;
                    retire   <= 1'b1;
                    state    <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
